// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampling UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_e;

    localparam int         DATA_BITS  = 8;
    localparam int         OVERSAMPLE = 16;
    localparam logic [3:0] SAMPLE_LO  = 4'd7;
    localparam logic [3:0] SAMPLE_MID = 4'd8;
    localparam logic [3:0] SAMPLE_HI  = 4'd9;
    localparam logic [3:0] SAMPLE_END = 4'd15;
    localparam logic [2:0] LAST_BIT   = 3'(DATA_BITS - 1);

    // Clocks per sample tick; never below one.
    function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
        int d;
        d = clk_freq / (baud * oversample);
        if (d < 1) begin
            calc_div = 1;
        end else begin
            calc_div = d;
        end
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        majority3 = (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead circular receive buffer; pointers carry one extra wrap bit.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             do_push_s;
    logic             do_pop_s;

    // A full buffer still takes a push when the head leaves in the same cycle.
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | pop);

    assign empty   = (wr_ptr_r == rd_ptr_r);
    assign full    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign rd_data = mem_r[rd_ptr_r[AW-1:0]];

    // Storage and pointer update; reset flushes contents so rd_data reads zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
                wr_ptr_r                <= wr_ptr_r + 1'b1;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_buffered.sv
// 16x-oversampled 8N1 UART receiver with majority voting and a receive FIFO.
// Defining UART_RX_PARITY_EN switches the frame to 8E1 and adds parity_err.
module uart_rx_buffered
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       Clock,
    input  logic       reset,
    input  logic       RxD,
    input  logic       rd_en,
    input  logic       clr_err,
    output logic [7:0] rd_data,
    output logic       empty,
    output logic       full,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       frame_err,
    output logic       overrun
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic          sync1_r, rxs_r;
    logic [TW-1:0] tick_cnt_r;
    logic          tick_s, at_hi_s, at_end_s, maj_s;
    rx_state_e     state_r;
    logic [3:0]    sample_cnt_r;
    logic [2:0]    bit_idx_r;
    logic [7:0]    shift_r;
    logic          samp_lo_r, samp_mid_r;
    logic          push_s, frame_set_s, overrun_set_s;
    logic          frame_err_r, overrun_r;
`ifdef UART_RX_PARITY_EN
    logic          par_bad_r, parity_err_r, parity_set_s;
`endif

    assign tick_s   = (tick_cnt_r == TW'(DIV - 1));
    assign at_hi_s  = tick_s && (sample_cnt_r == SAMPLE_HI);
    assign at_end_s = tick_s && (sample_cnt_r == SAMPLE_END);
    assign maj_s    = majority3(samp_lo_r, samp_mid_r, rxs_r);

    // Two-flop synchronizer for the asynchronous line.
    always_ff @(posedge Clock) begin
        if (reset) begin
            sync1_r <= 1'b1;
            rxs_r   <= 1'b1;
        end else begin
            sync1_r <= RxD;
            rxs_r   <= sync1_r;
        end
    end

    // Sample tick divider, held at zero while idle so each frame is phase-aligned.
    always_ff @(posedge Clock) begin
        if (reset || state_r == IDLE || tick_s) begin
            tick_cnt_r <= '0;
        end else begin
            tick_cnt_r <= tick_cnt_r + 1'b1;
        end
    end

    // Receive state machine with mid-bit sampling.
    always_ff @(posedge Clock) begin
        if (reset) begin
            state_r      <= IDLE;
            sample_cnt_r <= 4'd0;
            bit_idx_r    <= 3'd0;
            shift_r      <= 8'd0;
            samp_lo_r    <= 1'b0;
            samp_mid_r   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_r    <= 1'b0;
`endif
        end else begin
            if (state_r != IDLE && tick_s) begin
                sample_cnt_r <= sample_cnt_r + 4'd1;
                if (sample_cnt_r == SAMPLE_LO)  samp_lo_r  <= rxs_r;
                if (sample_cnt_r == SAMPLE_MID) samp_mid_r <= rxs_r;
            end
            case (state_r)
                IDLE: begin
                    sample_cnt_r <= 4'd0;
                    bit_idx_r    <= 3'd0;
`ifdef UART_RX_PARITY_EN
                    par_bad_r    <= 1'b0;
`endif
                    if (!rxs_r) state_r <= START;
                end
                START: begin
                    if (at_hi_s && maj_s) begin
                        state_r <= IDLE;
                    end else if (at_end_s) begin
                        state_r   <= DATA;
                        bit_idx_r <= 3'd0;
                    end
                end
                DATA: begin
                    if (at_hi_s) shift_r <= {maj_s, shift_r[7:1]};
                    if (at_end_s) begin
                        if (bit_idx_r == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state_r <= PARITY;
`else
                            state_r <= STOP;
`endif
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (at_hi_s)  par_bad_r <= maj_s ^ (^shift_r);
                    if (at_end_s) state_r   <= STOP;
                end
`endif
                STOP: begin
                    if (at_hi_s) state_r <= maj_s ? IDLE : BREAK;
                end
                BREAK: begin
                    if (rxs_r) state_r <= IDLE;
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    // Stop-bit verdict: deliver the byte or flag a framing error.
    always_comb begin
        push_s      = 1'b0;
        frame_set_s = 1'b0;
        if (state_r == STOP && at_hi_s) begin
            if (maj_s) begin
`ifdef UART_RX_PARITY_EN
                push_s = ~par_bad_r;
`else
                push_s = 1'b1;
`endif
            end else begin
                frame_set_s = 1'b1;
            end
        end else begin
            push_s      = 1'b0;
            frame_set_s = 1'b0;
        end
    end

    assign overrun_set_s = push_s & full & ~rd_en;
`ifdef UART_RX_PARITY_EN
    assign parity_set_s  = (state_r == PARITY) && at_hi_s && (maj_s ^ (^shift_r));
`endif

    // Sticky error flags; a new event outranks a simultaneous clear.
    always_ff @(posedge Clock) begin
        if (reset) begin
            frame_err_r  <= 1'b0;
            overrun_r    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_r <= 1'b0;
`endif
        end else begin
            frame_err_r  <= frame_set_s   | (frame_err_r  & ~clr_err);
            overrun_r    <= overrun_set_s | (overrun_r    & ~clr_err);
`ifdef UART_RX_PARITY_EN
            parity_err_r <= parity_set_s  | (parity_err_r & ~clr_err);
`endif
        end
    end

    assign frame_err  = frame_err_r;
    assign overrun    = overrun_r;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_r;
`endif

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (Clock),
        .reset   (reset),
        .push    (push_s),
        .pop     (rd_en),
        .wr_data (shift_r),
        .rd_data (rd_data),
        .empty   (empty),
        .full    (full)
    );

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Directed self-checking bench for uart_rx_buffered at 16 clocks per bit.
module tb_uart_rx_buffered;

    logic       Clock   = 1'b0;
    logic       reset   = 1'b1;
    logic       RxD     = 1'b1;
    logic       rd_en   = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] rd_data;
    logic       empty, full, frame_err, overrun;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int tests = 0;
    int fails = 0;

    uart_rx_buffered #(
        .CLK_FREQ   (1600000),
        .BAUD       (100000),
        .OVERSAMPLE (16),
        .FIFO_DEPTH (8)
    ) dut (
        .Clock     (Clock),
        .reset     (reset),
        .RxD       (RxD),
        .rd_en     (rd_en),
        .clr_err   (clr_err),
        .rd_data   (rd_data),
        .empty     (empty),
        .full      (full),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle(input int n);
        RxD = 1'b1;
        repeat (n) step();
    endtask

    // One 160-clock frame; cycle k drives frame bit k/16 just after edge k.
    // The stop decision lands on edge 157 (2 sync flops + 1 idle-detect + 16 + 8*16 + 10).
    task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                              input bit chk_lat, input bit pop_at_push);
        logic [9:0] fr;
        fr = {stop_bit, data, 1'b0};
        for (int k = 0; k < 160; k++) begin
            step();
            RxD = fr[k/16];
            if (chk_lat && k == 156) check("empty_before_push", {7'd0, empty}, 8'h01);
            if (chk_lat && k == 157) check("empty_after_push", {7'd0, empty}, 8'h00);
            if (pop_at_push && k == 156) rd_en = 1'b1;
            if (pop_at_push && k == 157) rd_en = 1'b0;
        end
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        check(tag, rd_data, exp);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_empty"},     {7'd0, empty},     8'h01);
        check({tag, "_full"},      {7'd0, full},      8'h00);
        check({tag, "_rd_data"},   rd_data,           8'h00);
        check({tag, "_frame_err"}, {7'd0, frame_err}, 8'h00);
        check({tag, "_overrun"},   {7'd0, overrun},   8'h00);
    endtask

    initial begin
        logic [9:0] fr;

        repeat (3) step();
        reset = 1'b0;
        step();
        check_reset_outputs("reset");

        // Two back-to-back good bytes.
        idle(20);
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
        idle(20);
        pop_check("byte_a5", 8'hA5);
        pop_check("byte_3c", 8'h3C);
        check("basic_empty", {7'd0, empty}, 8'h01);
        check("basic_frame_err", {7'd0, frame_err}, 8'h00);
        check("basic_overrun", {7'd0, overrun}, 8'h00);

        // Short low glitch must be rejected.
        for (int i = 0; i < 5; i++) begin
            step();
            RxD = 1'b0;
        end
        idle(40);
        check("glitch_empty", {7'd0, empty}, 8'h01);
        check("glitch_frame_err", {7'd0, frame_err}, 8'h00);
        check("glitch_overrun", {7'd0, overrun}, 8'h00);

        // Low stop bit then a long break: exactly one framing error.
        send_frame(8'h55, 1'b0, 1'b0, 1'b0);
        check("frame_err_set", {7'd0, frame_err}, 8'h01);
        check("frame_empty", {7'd0, empty}, 8'h01);
        for (int i = 0; i < 640; i++) begin
            step();
            RxD     = 1'b0;
            clr_err = (i == 320);
        end
        check("break_single_err", {7'd0, frame_err}, 8'h00);
        check("break_empty", {7'd0, empty}, 8'h01);
        idle(32);
        send_frame(8'h12, 1'b1, 1'b0, 1'b0);
        idle(20);
        pop_check("after_break", 8'h12);
        check("after_break_empty", {7'd0, empty}, 8'h01);

        // Nine bytes with no reads: overrun, first eight kept in order.
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1, 1'b0, 1'b0);
        idle(20);
        check("ovr_full", {7'd0, full}, 8'h01);
        check("ovr_flag", {7'd0, overrun}, 8'h01);
        for (int i = 1; i <= 8; i++) pop_check("ovr_pop", 8'(i));
        check("ovr_drained", {7'd0, empty}, 8'h01);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        check("ovr_cleared", {7'd0, overrun}, 8'h00);

        // Pop coinciding with the push into a full FIFO.
        for (int i = 0; i < 8; i++) send_frame(8'h11 + 8'(i), 1'b1, 1'b0, 1'b0);
        check("sim_full_before", {7'd0, full}, 8'h01);
        send_frame(8'h19, 1'b1, 1'b0, 1'b1);
        idle(10);
        check("sim_full_after", {7'd0, full}, 8'h01);
        check("sim_no_overrun", {7'd0, overrun}, 8'h00);
        for (int i = 0; i < 8; i++) pop_check("sim_pop", 8'h12 + 8'(i));
        check("sim_drained", {7'd0, empty}, 8'h01);

        // Put a frame error and a byte in place, then reset during bit 4.
        send_frame(8'h77, 1'b0, 1'b0, 1'b0);
        idle(32);
        send_frame(8'h66, 1'b1, 1'b0, 1'b0);
        idle(10);
        check("pre_reset_frame_err", {7'd0, frame_err}, 8'h01);
        check("pre_reset_data", rd_data, 8'h66);
        fr = {1'b1, 8'hF0, 1'b0};
        for (int k = 0; k < 88; k++) begin
            step();
            RxD = fr[k/16];
        end
        reset = 1'b1;
        RxD   = 1'b1;
        step();
        check_reset_outputs("midframe_reset");
        reset = 1'b0;
        idle(32);
        send_frame(8'h81, 1'b1, 1'b1, 1'b0);
        idle(5);
        pop_check("post_reset_byte", 8'h81);
        check("post_reset_empty", {7'd0, empty}, 8'h01);
        check("post_reset_frame_err", {7'd0, frame_err}, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
